// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel data mux with round-robin arbitration.
// Optional build macro: MUX_ND_LOCK_EN (burst lock in round-robin mode).
package mux_pkg;

  // Operating mode carried on the 1-bit mode input.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Grant computation for mux_nd_arb: fixed select or rotating-priority search
// starting after the last round-robin grant, with an optional burst lock.
// Optional build macro: MUX_ND_LOCK_EN.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_w(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mode_i,
  input  logic [SEL_W-1:0]    mux_ctl_i,
  input  logic [CHANNELS-1:0] valid_i,
  input  logic [CHANNELS-1:0] last_i,
  input  logic                load_i,
  output logic [SEL_W-1:0]    grant_o,
  output logic                grant_valid_o
);

  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] cand;

`ifdef MUX_ND_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_last;
  assign unused_last = ^last_i;
`endif

  // Rotating-priority search: first valid channel from last_q+1 upward, wrapping.
  always_comb begin
    rr_grant = last_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      cand = SEL_W'((32'(last_q) + k) % 32'(CHANNELS));
      if (!rr_found && valid_i[cand]) begin
        rr_grant = cand;
        rr_found = 1'b1;
      end
    end
  end

  // Grant selection: fixed select, locked channel, or rotating search result.
  always_comb begin
    grant_o       = mux_ctl_i;
    grant_valid_o = 1'b0;
    if (mode_i == MODE_FIXED) begin
      grant_o       = mux_ctl_i;
      grant_valid_o = (32'(mux_ctl_i) < 32'(CHANNELS)) && valid_i[mux_ctl_i];
`ifdef MUX_ND_LOCK_EN
    end else if (lock_q) begin
      // The locked channel is always the last round-robin grant, so last_q
      // doubles as the lock owner; no separate owner register is needed.
      grant_o       = last_q;
      grant_valid_o = valid_i[last_q];
`endif
    end else begin
      grant_o       = rr_grant;
      grant_valid_o = rr_found;
    end
  end

  // Next pointer/lock: only round-robin loads move them.
  always_comb begin
    last_d = last_q;
`ifdef MUX_ND_LOCK_EN
    lock_d = lock_q;
`endif
    if (load_i && (mode_i == MODE_RR)) begin
      last_d = grant_o;
`ifdef MUX_ND_LOCK_EN
      lock_d = !last_i[grant_o];
`endif
    end
  end

  // Pointer (and lock) registers; reset gives channel 0 first priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= SEL_W'(CHANNELS - 1);
`ifdef MUX_ND_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else begin
      last_q <= last_d;
`ifdef MUX_ND_LOCK_EN
      lock_q <= lock_d;
`endif
    end
  end

endmodule

// File: rtl/mux_nd_arb.sv
// N-channel valid/ready data mux with a registered output stage.
// Channel choice comes from mux_rr_arbiter (fixed or round-robin).
// Optional build macro: MUX_ND_LOCK_EN (burst lock, handled in the arbiter).
module mux_nd_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          mux_ctl,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       din_valid,
  input  logic [CHANNELS-1:0]       din_last,
  output logic [CHANNELS-1:0]       din_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_sel,
  output logic                      dout_valid,
  input  logic                      dout_ready
);

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             free;
  logic             load;
  logic [WIDTH-1:0] din_sel;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;

  mux_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mode_i        (mode),
    .mux_ctl_i     (mux_ctl),
    .valid_i       (din_valid),
    .last_i        (din_last),
    .load_i        (load),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  // Output register can take a beat when empty or being drained this cycle.
  assign free = !valid_q || dout_ready;
  assign load = rst_n && free && grant_valid;

  // Handshake back to the granted channel only.
  always_comb begin
    din_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      din_ready[i] = load && (grant == SEL_W'(i));
    end
  end

  // Data select for the granted channel.
  always_comb begin
    din_sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        din_sel = din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage next state: load, drain, or hold under back-pressure.
  always_comb begin
    dout_d  = dout_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (load) begin
      dout_d  = din_sel;
      sel_d   = grant;
      valid_d = 1'b1;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output registers; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_sel   = sel_q;
  assign dout_valid = valid_q;

endmodule
